cpu_control_unit: RTL and testbench

- Multi-cycle sequencer for the 8-bit CPU.
- Fetches opcode and operand bytes over a req/ack memory port and presents the instruction register to the combinational instruction decoder.
- Uses the decoder's class outputs to run memory-access, execute and writeback phases, and parks the core on halt.
- Sits between the memory interface, the PC/SP units, the register file and the ALU.

---
 rtl/cpu_control_unit.sv | 111 +++++++++++
 tb/tb_cpu_control_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_unit.sv
// rtl/cpu_control_unit.sv - multi-cycle fetch/decode/execute sequencer for the 8-bit CPU
module cpu_control_unit #(
    parameter int ADDR_SEL_W = 2,
    parameter int OPERAND_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_SEL_W-1:0] mem_addr_sel,
    input  logic                  mem_ack,
    input  logic [7:0]            mem_rdata,
    output logic [7:0]            ir,
    output logic [OPERAND_W-1:0]  operand,
    output logic [7:0]            mdr,
    input  logic [1:0]            dec_length,
    input  logic                  dec_mem_read,
    input  logic                  dec_mem_write,
    input  logic                  dec_reg_write,
    input  logic                  dec_halt,
    input  logic                  dec_call,
    input  logic                  dec_ret,
    input  logic [1:0]            dec_pc_src,
    output logic                  pc_inc,
    output logic                  pc_load,
    output logic                  sp_push,
    output logic                  sp_pop,
    output logic                  alu_en,
    output logic                  reg_we,
    output logic                  halted,
    output logic [2:0]            state
);

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        OPERAND   = 3'd2,
        MEMACC    = 3'd3,
        EXECUTE   = 3'd4,
        WRITEBACK = 3'd5,
        HALT      = 3'd6,
        UNUSED    = 3'd7
    } state_t;

    state_t     cur;
    logic [1:0] byte_cnt;
    logic [1:0] eff_len;
    state_t     dispatch;

    // A zero length from the decoder still means a single opcode byte.
    assign eff_len  = (dec_length == 2'd0) ? 2'd1 : dec_length;
    assign dispatch = dec_halt ? HALT :
                      (dec_mem_read || dec_mem_write) ? MEMACC : EXECUTE;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur      <= FETCH;
            ir       <= 8'h00;
            operand  <= '0;
            mdr      <= 8'h00;
            byte_cnt <= 2'd0;
        end else begin
            case (cur)
                FETCH: begin
                    if (mem_ack) begin
                        ir       <= mem_rdata;
                        byte_cnt <= 2'd1;
                        cur      <= DECODE;
                    end
                end
                DECODE: cur <= (eff_len > 2'd1) ? OPERAND : dispatch;
                OPERAND: begin
                    if (mem_ack) begin
                        if (byte_cnt == 2'd1)
                            operand[7:0] <= mem_rdata;
                        else if (byte_cnt == 2'd2)
                            operand[15:8] <= mem_rdata;
                        byte_cnt <= 2'(byte_cnt + 2'd1);
                        if (2'(byte_cnt + 2'd1) == eff_len)
                            cur <= dispatch;
                    end
                end
                MEMACC: begin
                    if (mem_ack) begin
                        // A write flag overrides a simultaneous read flag.
                        if (dec_mem_read && !dec_mem_write)
                            mdr <= mem_rdata;
                        cur <= EXECUTE;
                    end
                end
                EXECUTE:   cur <= dec_reg_write ? WRITEBACK : FETCH;
                WRITEBACK: cur <= FETCH;
                HALT:      cur <= HALT;
                default:   cur <= FETCH;
            endcase
        end
    end

    assign state        = cur;
    assign mem_req      = !rst && (cur == FETCH || cur == OPERAND || cur == MEMACC);
    assign mem_we       = !rst && (cur == MEMACC) && dec_mem_write;
    assign mem_addr_sel = (cur == MEMACC) ? ADDR_SEL_W'(1) : '0;
    assign pc_inc       = !rst && mem_ack && (cur == FETCH || cur == OPERAND);
    assign pc_load      = !rst && (cur == EXECUTE) && (dec_pc_src != 2'd0);
    assign sp_push      = !rst && (cur == EXECUTE) && dec_call;
    assign sp_pop       = !rst && (cur == EXECUTE) && dec_ret;
    assign alu_en       = !rst && (cur == EXECUTE);
    assign reg_we       = !rst && (cur == WRITEBACK);
    assign halted       = (cur == HALT);

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb/tb_cpu_control_unit.sv - randomized bench for cpu_control_unit against a phase-list model
module tb_cpu_control_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we;
    logic [1:0]  mem_addr_sel;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  ir, mdr;
    logic [15:0] operand;
    logic [1:0]  dec_length, dec_pc_src;
    logic        dec_mem_read, dec_mem_write, dec_reg_write, dec_halt, dec_call, dec_ret;
    logic        pc_inc, pc_load, sp_push, sp_pop, alu_en, reg_we, halted;
    logic [2:0]  state;

    cpu_control_unit #(.ADDR_SEL_W(2), .OPERAND_W(16)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ir(ir), .operand(operand), .mdr(mdr), .dec_length(dec_length),
        .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
        .dec_reg_write(dec_reg_write), .dec_halt(dec_halt), .dec_call(dec_call),
        .dec_ret(dec_ret), .dec_pc_src(dec_pc_src), .pc_inc(pc_inc),
        .pc_load(pc_load), .sp_push(sp_push), .sp_pop(sp_pop), .alu_en(alu_en),
        .reg_we(reg_we), .halted(halted), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] len;
        logic       mr, mw, rw, halt, call, ret;
        logic [1:0] pc_src;
    } dec_t;

    function automatic dec_t decode(input logic [7:0] op);
        dec_t d;
        d = '0;
        case (op)
            8'h00: d.len = 2'd1;
            8'hA5: begin d.len = 2'd2; d.rw = 1'b1; end
            8'h20: begin d.len = 2'd3; d.mw = 1'b1; end
            8'h10: begin d.len = 2'd1; d.mr = 1'b1; d.rw = 1'b1; end
            8'hC0: begin d.len = 2'd1; d.call = 1'b1; d.pc_src = 2'd1; end
            8'hD0: begin d.len = 2'd1; d.ret = 1'b1; d.pc_src = 2'd2; end
            8'hF0: begin d.len = 2'd1; d.halt = 1'b1; end
            default: begin
                d.len    = op[1:0];
                d.mr     = op[2];
                d.mw     = op[3];
                d.rw     = op[4];
                d.pc_src = op[6:5];
                d.call   = op[7] & ~op[0];
                d.ret    = op[7] & op[0];
            end
        endcase
        return d;
    endfunction

    dec_t env_dec;
    assign env_dec       = decode(ir);
    assign dec_length    = env_dec.len;
    assign dec_mem_read  = env_dec.mr;
    assign dec_mem_write = env_dec.mw;
    assign dec_reg_write = env_dec.rw;
    assign dec_halt      = env_dec.halt;
    assign dec_call      = env_dec.call;
    assign dec_ret       = env_dec.ret;
    assign dec_pc_src    = env_dec.pc_src;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    // One expected cycle: observable outputs, the memory response to drive,
    // and which register the model loads at the closing edge.
    typedef struct packed {
        logic [13:0] out;
        logic        ack;
        logic [7:0]  rdata;
        logic [2:0]  ld;
    } cycle_t;

    cycle_t      q[$];
    logic [7:0]  exp_ir = 8'h00, exp_mdr = 8'h00;
    logic [15:0] exp_opnd = 16'h0000;

    function automatic logic [13:0] mk(input logic [2:0] st, input logic req, input logic [1:0] sel,
                                       input logic we, input logic inc, input logic ldpc,
                                       input logic push, input logic pop, input logic alu,
                                       input logic rw, input logic h);
        return {st, req, sel, we, inc, ldpc, push, pop, alu, rw, h};
    endfunction

    function automatic logic [13:0] observed();
        return {state, mem_req, mem_addr_sel, mem_we, pc_inc, pc_load, sp_push, sp_pop,
                alu_en, reg_we, halted};
    endfunction

    task automatic add_req(input logic [2:0] st, input logic [1:0] sel, input logic we,
                           input logic inc, input int waits, input logic [7:0] data,
                           input logic [2:0] ld);
        cycle_t c;
        for (int k = 0; k < waits; k++) begin
            c = {mk(st, 1'b1, sel, we, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
                 1'b0, 8'($urandom), 3'd0};
            q.push_back(c);
        end
        c = {mk(st, 1'b1, sel, we, inc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, data, ld};
        q.push_back(c);
    endtask

    // Cycles with no request see random acks, which must be ignored.
    task automatic add_free(input logic [13:0] o);
        cycle_t c;
        c = {o, 1'($urandom), 8'($urandom), 3'd0};
        q.push_back(c);
    endtask

    task automatic run_instr(input logic [7:0] op, input logic [7:0] b2, input logic [7:0] b3,
                             input int fw, input int ow, input int mw, input int stop_after);
        dec_t d;
        int   len;
        d   = decode(op);
        len = (d.len == 2'd0) ? 1 : int'(d.len);
        q.delete();
        add_req(3'd0, 2'd0, 1'b0, 1'b1, fw, op, 3'd1);
        add_free(mk(3'd1, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i < len; i++)
            add_req(3'd2, 2'd0, 1'b0, 1'b1, ow, (i == 1) ? b2 : b3, (i == 1) ? 3'd2 : 3'd3);
        if (d.halt) begin
            for (int i = 0; i < 20; i++)
                add_free(mk(3'd6, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1));
        end else begin
            if (d.mr || d.mw)
                add_req(3'd3, 2'd1, d.mw, 1'b0, mw, 8'($urandom),
                        (d.mr && !d.mw) ? 3'd4 : 3'd0);
            add_free(mk(3'd4, 0, 2'd0, 0, 0, d.pc_src != 2'd0, d.call, d.ret, 1, 0, 0));
            if (d.rw)
                add_free(mk(3'd5, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0));
        end
        if (stop_after >= 0)
            while (q.size() > stop_after) void'(q.pop_back());
        foreach (q[i]) begin
            @(negedge clk);
            mem_ack   = q[i].ack;
            mem_rdata = q[i].rdata;
            #1;
            check($sformatf("cyc op=%h i=%0d", op, i), 32'(observed()), 32'(q[i].out));
            check($sformatf("regs op=%h i=%0d", op, i), {ir, operand, mdr},
                  {exp_ir, exp_opnd, exp_mdr});
            case (q[i].ld)
                3'd1: exp_ir = q[i].rdata;
                3'd2: exp_opnd[7:0] = q[i].rdata;
                3'd3: exp_opnd[15:8] = q[i].rdata;
                3'd4: exp_mdr = q[i].rdata;
                default: ;
            endcase
        end
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rst       = 1'b1;
            mem_ack   = 1'b1;
            mem_rdata = 8'($urandom);
            #1;
            check("rst_strobes", {24'h0, mem_req, mem_we, pc_inc, pc_load, sp_push, sp_pop,
                                  alu_en, reg_we}, 32'h0);
        end
        @(negedge clk);
        rst     = 1'b0;
        mem_ack = 1'b0;
        #1;
        exp_ir   = 8'h00;
        exp_opnd = 16'h0000;
        exp_mdr  = 8'h00;
        check("rst_state", 32'(state), 32'd0);
        check("rst_regs", {ir, operand, mdr}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] op;
        do_reset(2);
        run_instr(8'h00, 8'h00, 8'h00, 0, 0, 0, -1);
        run_instr(8'h00, 8'h00, 8'h00, 0, 0, 0, -1);
        run_instr(8'hA5, 8'h5A, 8'h00, 0, 0, 0, -1);
        run_instr(8'h20, 8'h34, 8'h12, 0, 0, 0, -1);
        run_instr(8'h10, 8'h00, 8'h00, 0, 0, 3, -1);
        run_instr(8'hC0, 8'h00, 8'h00, 0, 0, 0, -1);
        run_instr(8'hD0, 8'h00, 8'h00, 0, 0, 0, -1);
        for (int n = 0; n < 200; n++) begin
            op = 8'($urandom);
            if (op == 8'hF0) op = 8'h00;
            run_instr(op, 8'($urandom), 8'($urandom), $urandom_range(0, 2),
                      $urandom_range(0, 2), $urandom_range(0, 3), -1);
        end
        // Abandon an operand fetch mid-wait: fetch, decode, two wait cycles.
        run_instr(8'h20, 8'h77, 8'h66, 0, 3, 0, 4);
        do_reset(1);
        run_instr(8'hA5, 8'h3C, 8'h00, 1, 1, 0, -1);
        run_instr(8'hF0, 8'h00, 8'h00, 0, 0, 0, -1);
        do_reset(1);
        run_instr(8'h10, 8'h00, 8'h00, 2, 0, 1, -1);
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
